// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch FSM: reads opcode (and operand) bytes, presents them to the decoder.
// Optional build macro FETCH_ILLEGAL_TRAP_EN: opcodes 0xC?/0xD? set a sticky illegal flag and halt.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        flush,
  input  logic [7:0]  pc_addr,
  output logic        pc_inc,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_operand,
  output logic        instr_two_byte,
  output logic        illegal,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    FETCH_ARG = 3'd2,
    PRESENT   = 3'd3,
    HALTED    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  state_t      resume_s;
  logic        mem_req_q, mem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  operand_q, operand_d;
  logic        two_byte_q, two_byte_d;
  logic [15:0] count_q, count_d;
  logic        ack_take_s;
  logic        handshake_s;

  function automatic logic is_two_byte(input logic [7:0] op);
    case (op[7:4])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7,
      4'h8, 4'h9, 4'hA, 4'hB: is_two_byte = 1'b1;
      default:                is_two_byte = 1'b0;
    endcase
  endfunction

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  function automatic logic is_trap_op(input logic [7:0] op);
    is_trap_op = (op[7:4] == 4'hC) || (op[7:4] == 4'hD);
  endfunction
`endif

  // A flush squashes any byte arriving in the same cycle, so it never reaches the PC or the latches.
  assign ack_take_s  = mem_req_q & mem_ack & ~flush;
  assign handshake_s = instr_valid_q & instr_ready;
  assign resume_s    = run ? FETCH_OP : IDLE;

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    two_byte_d = two_byte_q;
    count_d    = count_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    if (handshake_s) begin
      count_d = count_q + 16'd1;
    end
    if (flush && (state_q != HALTED)) begin
      state_d = resume_s;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) state_d = FETCH_OP;
          else     state_d = IDLE;
        end
        FETCH_OP: begin
          if (ack_take_s) begin
            opcode_d   = mem_rdata;
            two_byte_d = is_two_byte(mem_rdata);
            if (is_two_byte(mem_rdata)) begin
              state_d = FETCH_ARG;
            end else begin
              operand_d = 8'h00;
              state_d   = PRESENT;
            end
          end else begin
            state_d = FETCH_OP;
          end
        end
        FETCH_ARG: begin
          if (ack_take_s) begin
            operand_d = mem_rdata;
            state_d   = PRESENT;
          end else begin
            state_d = FETCH_ARG;
          end
        end
        PRESENT: begin
          if (handshake_s) begin
            if (opcode_q[7:4] == 4'hF) begin
              state_d = HALTED;
            end
`ifdef FETCH_ILLEGAL_TRAP_EN
            else if (is_trap_op(opcode_q)) begin
              illegal_d = 1'b1;
              state_d   = HALTED;
            end
`endif
            else begin
              state_d = resume_s;
            end
          end else begin
            state_d = PRESENT;
          end
        end
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
    mem_req_d     = (state_d == FETCH_OP) || (state_d == FETCH_ARG);
    instr_valid_d = (state_d == PRESENT);
    halted_d      = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      opcode_q      <= 8'h00;
      operand_q     <= 8'h00;
      two_byte_q    <= 1'b0;
      count_q       <= 16'h0000;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      two_byte_q    <= two_byte_d;
      count_q       <= count_d;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_q     <= illegal_d;
`endif
    end
  end

  assign pc_inc         = ack_take_s;
  assign mem_req        = mem_req_q;
  assign mem_addr       = pc_addr;
  assign instr_valid    = instr_valid_q;
  assign instr_opcode   = opcode_q;
  assign instr_operand  = operand_q;
  assign instr_two_byte = two_byte_q;
  assign halted         = halted_q;
  assign instr_count    = count_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
  assign illegal        = illegal_q;
`else
  assign illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus hand sequences for halt, reset and count wrap.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic        flush;
  logic [7:0]  pc_addr;
  logic        pc_inc;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_operand;
  logic        instr_two_byte;
  logic        illegal;
  logic        halted;
  logic [15:0] instr_count;

  int checks;
  int failures;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .flush          (flush),
    .pc_addr        (pc_addr),
    .pc_inc         (pc_inc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_operand  (instr_operand),
    .instr_two_byte (instr_two_byte),
    .illegal        (illegal),
    .halted         (halted),
    .instr_count    (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        flush;
    logic        ack;
    logic [7:0]  rdata;
    logic        ready;
    logic        e_req;
    logic        e_inc;
    logic        e_valid;
    logic [7:0]  e_op;
    logic [7:0]  e_opd;
    logic        e_two;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic a, input logic [7:0] d, input logic rdy,
                     input logic eq, input logic ei, input logic ev, input logic [7:0] eo,
                     input logic [7:0] ed, input logic et, input logic [15:0] ec);
    vec_t v;
    v.run = r; v.flush = f; v.ack = a; v.rdata = d; v.ready = rdy;
    v.e_req = eq; v.e_inc = ei; v.e_valid = ev; v.e_op = eo; v.e_opd = ed; v.e_two = et; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic a, input logic [7:0] d, input logic rdy);
    run = r; flush = f; mem_ack = a; mem_rdata = d; instr_ready = rdy;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " mem_req"}, {15'd0, mem_req}, 16'd0);
    chk({tag, " pc_inc"}, {15'd0, pc_inc}, 16'd0);
    chk({tag, " valid"}, {15'd0, instr_valid}, 16'd0);
    chk({tag, " halted"}, {15'd0, halted}, 16'd0);
    chk({tag, " illegal"}, {15'd0, illegal}, 16'd0);
    chk({tag, " opcode"}, {8'd0, instr_opcode}, 16'd0);
    chk({tag, " operand"}, {8'd0, instr_operand}, 16'd0);
    chk({tag, " count"}, instr_count, 16'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    pc_addr = 8'h10;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // run flush ack rdata ready | req inc valid op opd two cnt
    add(1,0,0,8'h00,0, 0,0,0,8'h00,8'h00,0,16'd0);  // one-byte NOT at 0x10
    add(1,0,1,8'h60,1, 1,1,0,8'h00,8'h00,0,16'd0);
    add(0,0,0,8'h00,1, 0,0,1,8'h60,8'h00,0,16'd0);
    add(0,0,0,8'h00,0, 0,0,0,8'h60,8'h00,0,16'd1);
    add(1,0,0,8'h00,0, 0,0,0,8'h60,8'h00,0,16'd1);  // two-byte LDA 0x80, 3 wait cycles per byte
    for (int i = 0; i < 3; i++) add(1,0,0,8'h00,0, 1,0,0,8'h60,8'h00,0,16'd1);
    add(1,0,1,8'h20,0, 1,1,0,8'h60,8'h00,0,16'd1);
    for (int i = 0; i < 3; i++) add(1,0,0,8'h00,0, 1,0,0,8'h20,8'h00,1,16'd1);
    add(1,0,1,8'h80,0, 1,1,0,8'h20,8'h00,1,16'd1);
    for (int i = 0; i < 5; i++) add(1,0,0,8'h00,0, 0,0,1,8'h20,8'h80,1,16'd1);
    add(1,0,0,8'h00,1, 0,0,1,8'h20,8'h80,1,16'd1);
    add(1,0,1,8'h30,0, 1,1,0,8'h20,8'h80,1,16'd2);  // flush with ack in FETCH_ARG
    add(1,1,1,8'h55,0, 1,0,0,8'h30,8'h80,1,16'd2);
    add(1,0,1,8'h00,0, 1,1,0,8'h30,8'h80,1,16'd2);
    add(1,1,0,8'h00,1, 0,0,1,8'h00,8'h00,0,16'd2);  // handshake coincident with flush
    add(0,0,0,8'h00,0, 1,0,0,8'h00,8'h00,0,16'd3);  // run=0 does not abort the fetch
    add(0,0,1,8'hC0,0, 1,1,0,8'h00,8'h00,0,16'd3);
    add(1,0,0,8'h00,1, 0,0,1,8'hC0,8'h00,0,16'd3);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].run, vecs[i].flush, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
      #1;
      chk($sformatf("v%0d mem_req", i), {15'd0, mem_req}, {15'd0, vecs[i].e_req});
      chk($sformatf("v%0d pc_inc", i), {15'd0, pc_inc}, {15'd0, vecs[i].e_inc});
      chk($sformatf("v%0d valid", i), {15'd0, instr_valid}, {15'd0, vecs[i].e_valid});
      chk($sformatf("v%0d opcode", i), {8'd0, instr_opcode}, {8'd0, vecs[i].e_op});
      chk($sformatf("v%0d operand", i), {8'd0, instr_operand}, {8'd0, vecs[i].e_opd});
      chk($sformatf("v%0d two_byte", i), {15'd0, instr_two_byte}, {15'd0, vecs[i].e_two});
      chk($sformatf("v%0d count", i), instr_count, vecs[i].e_cnt);
      chk($sformatf("v%0d halted", i), {15'd0, halted}, 16'd0);
      chk($sformatf("v%0d illegal", i), {15'd0, illegal}, 16'd0);
      if (vecs[i].e_req) chk($sformatf("v%0d mem_addr", i), {8'd0, mem_addr}, {8'd0, pc_addr});
      @(posedge clk);
      #1;
      if (vecs[i].e_inc) pc_addr = pc_addr + 8'd1;
    end

    // Outcome of handing 0xC0 to the decoder depends on the trap build.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("post_c0 count", instr_count, 16'd4);
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("trap illegal", {15'd0, illegal}, 16'd1);
    chk("trap halted", {15'd0, halted}, 16'd1);
    chk("trap mem_req", {15'd0, mem_req}, 16'd0);
`else
    chk("c0 illegal", {15'd0, illegal}, 16'd0);
    chk("c0 halted", {15'd0, halted}, 16'd0);
    chk("c0 next fetch", {15'd0, mem_req}, 16'd1);
`endif
    reset = 1'b0;
    #1;
    chk_reset_state("rst2");
    @(negedge clk);
    reset = 1'b1;

    // HLT: consumed, then run/flush/ack toggles must leave it halted.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 8'hF0, 1'b0);
    #1;
    chk("hlt pc_inc", {15'd0, pc_inc}, 16'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    chk("hlt valid", {15'd0, instr_valid}, 16'd1);
    chk("hlt opcode", {8'd0, instr_opcode}, 16'h00F0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(i[0], ~i[0], 1'b1, 8'h00, 1'b1);
      #1;
      chk($sformatf("halt%0d halted", i), {15'd0, halted}, 16'd1);
      chk($sformatf("halt%0d mem_req", i), {15'd0, mem_req}, 16'd0);
      chk($sformatf("halt%0d pc_inc", i), {15'd0, pc_inc}, 16'd0);
      chk($sformatf("halt%0d valid", i), {15'd0, instr_valid}, 16'd0);
      chk($sformatf("halt%0d count", i), instr_count, 16'd1);
    end
    reset = 1'b0;
    #1;
    chk("hlt_rst halted", {15'd0, halted}, 16'd0);
    chk("hlt_rst count", instr_count, 16'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;

    // Reset mid-fetch withdraws mem_req without waiting for a clock edge.
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("midfetch mem_req", {15'd0, mem_req}, 16'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async mem_req", {15'd0, mem_req}, 16'd0);
    @(negedge clk);
    run = 1'b0;
    reset = 1'b1;

    // Count wrap: preload the counter to 0xFFFF, then one handshake.
    @(negedge clk);
    force dut.count_d = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.count_d;
    #1;
    chk("preload count", instr_count, 16'hFFFF);
    run = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 8'h60, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    chk("wrap valid", {15'd0, instr_valid}, 16'd1);
    chk("wrap before", instr_count, 16'hFFFF);
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    chk("wrap count", instr_count, 16'h0000);
    chk("wrap idle", {15'd0, instr_valid}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
